// File: rtl/obi_fetch_adapter.sv
// OBI instruction-fetch to valid/ready cache-lookup adapter.
// Every fetch port has its own in-order request queue, an optional registered
// response stage, a kill (branch flush) input and a saturating stall counter.
// Ports share nothing; each one is an identical copy of the per-port logic.
module obi_fetch_adapter #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int ReqDepth  = 2,
  parameter int RspCut    = 1,
  parameter int CntWidth  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           fetch_req_i,
  input  logic [NumPorts*AddrWidth-1:0] fetch_addr_i,
  output logic [NumPorts-1:0]           fetch_gnt_o,
  output logic [NumPorts-1:0]           fetch_rvalid_o,
  output logic [NumPorts*DataWidth-1:0] fetch_rdata_o,
  output logic [NumPorts-1:0]           fetch_rerror_o,
  input  logic [NumPorts-1:0]           fetch_kill_i,
  output logic [NumPorts-1:0]           cache_valid_o,
  output logic [NumPorts*AddrWidth-1:0] cache_addr_o,
  input  logic [NumPorts-1:0]           cache_ready_i,
  input  logic [NumPorts*DataWidth-1:0] cache_rdata_i,
  input  logic [NumPorts-1:0]           cache_rerror_i,
  output logic [NumPorts*CntWidth-1:0]  stall_cnt_o,
  input  logic                          stall_cnt_clr_i
);

  localparam int PtrWidth = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int OccWidth = $clog2(ReqDepth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(ReqDepth - 1);
  localparam logic [OccWidth-1:0] FullOcc = OccWidth'(ReqDepth);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [AddrWidth-1:0] mem_q [ReqDepth];
    logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OccWidth-1:0]  occ_q, occ_d;
    logic [CntWidth-1:0]  stall_q, stall_d;
    logic                 req, kill, gnt, empty, full, pop, rsp_fire;

    assign req   = fetch_req_i[p];
    assign kill  = fetch_kill_i[p];
    assign empty = (occ_q == '0);
    assign full  = (occ_q == FullOcc);

    // Grant depends only on registered occupancy, so there is no path from
    // cache_ready_i to the grant; it is also held low while reset is asserted
    // so the core never sees a grant for a fetch that the reset is dropping.
    assign gnt      = req & ~full & ~kill & ~rst_i;
    assign pop      = ~empty & cache_ready_i[p];
    assign rsp_fire = pop & ~kill;

    assign fetch_gnt_o[p]                          = gnt;
    assign cache_valid_o[p]                        = ~empty;
    assign cache_addr_o[p*AddrWidth +: AddrWidth]  = empty ? '0 : mem_q[rptr_q];
    assign stall_cnt_o[p*CntWidth +: CntWidth]     = stall_q;

    // Queue pointer and occupancy update; a kill empties the queue outright.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (kill) begin
        wptr_d = '0;
        rptr_d = '0;
        occ_d  = '0;
      end else begin
        if (gnt) begin
          wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
        end
        if (pop) begin
          rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
        end
        if (gnt && !pop) begin
          occ_d = occ_q + OccWidth'(1);
        end else if (pop && !gnt) begin
          occ_d = occ_q - OccWidth'(1);
        end
      end
    end

    // Queue state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
      end
    end

    // Queue storage: the granted address is written at the tail.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < ReqDepth; i++) begin
          mem_q[i] <= '0;
        end
      end else if (gnt) begin
        mem_q[wptr_q] <= fetch_addr_i[p*AddrWidth +: AddrWidth];
      end
    end

    // Stall counter next value: clear beats increment, saturates at all-ones.
    always_comb begin
      stall_d = stall_q;
      if (stall_cnt_clr_i) begin
        stall_d = '0;
      end else if (req && !gnt && !(&stall_q)) begin
        stall_d = stall_q + CntWidth'(1);
      end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_d;
      end
    end

    if (RspCut != 0) begin : g_cut
      logic                 rvalid_q;
      logic [DataWidth-1:0] rdata_q;
      logic                 rerror_q;

      // Registered response: data captured on a surviving pop and held otherwise.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rvalid_q <= 1'b0;
          rdata_q  <= '0;
          rerror_q <= 1'b0;
        end else begin
          rvalid_q <= rsp_fire;
          if (rsp_fire) begin
            rdata_q  <= cache_rdata_i[p*DataWidth +: DataWidth];
            rerror_q <= cache_rerror_i[p];
          end
        end
      end

      assign fetch_rvalid_o[p]                        = rvalid_q;
      assign fetch_rdata_o[p*DataWidth +: DataWidth]  = rdata_q;
      assign fetch_rerror_o[p]                        = rerror_q;
    end else begin : g_nocut
      // Pass-through response, forced to zero when no response is being returned.
      assign fetch_rvalid_o[p]                        = rsp_fire;
      assign fetch_rdata_o[p*DataWidth +: DataWidth]  =
        rsp_fire ? cache_rdata_i[p*DataWidth +: DataWidth] : '0;
      assign fetch_rerror_o[p]                        = rsp_fire & cache_rerror_i[p];
    end
  end

endmodule

// File: tb/tb_obi_fetch_adapter.sv
// Testbench for obi_fetch_adapter: two instances (registered response with
// 16-bit counters, and pass-through response with 2-bit counters) see the same
// stimulus and are compared every cycle against a queue-based reference model.
module tb_obi_fetch_adapter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    req, kill, ready;
  logic [NP*AW-1:0] addr;
  logic             clr;

  logic [NP-1:0]    gntA, rvA, rerrA, cvA, crerrA;
  logic [NP*DW-1:0] rdataA, crdataA;
  logic [NP*AW-1:0] caddrA;
  logic [NP*16-1:0] stallA;

  logic [NP-1:0]    gntB, rvB, rerrB, cvB, crerrB;
  logic [NP*DW-1:0] rdataB, crdataB;
  logic [NP*AW-1:0] caddrB;
  logic [NP*2-1:0]  stallB;

  obi_fetch_adapter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .ReqDepth(2),
                      .RspCut(1), .CntWidth(16)) dutA (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(req), .fetch_addr_i(addr), .fetch_gnt_o(gntA),
    .fetch_rvalid_o(rvA), .fetch_rdata_o(rdataA), .fetch_rerror_o(rerrA),
    .fetch_kill_i(kill),
    .cache_valid_o(cvA), .cache_addr_o(caddrA), .cache_ready_i(ready),
    .cache_rdata_i(crdataA), .cache_rerror_i(crerrA),
    .stall_cnt_o(stallA), .stall_cnt_clr_i(clr)
  );

  obi_fetch_adapter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .ReqDepth(2),
                      .RspCut(0), .CntWidth(2)) dutB (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(req), .fetch_addr_i(addr), .fetch_gnt_o(gntB),
    .fetch_rvalid_o(rvB), .fetch_rdata_o(rdataB), .fetch_rerror_o(rerrB),
    .fetch_kill_i(kill),
    .cache_valid_o(cvB), .cache_addr_o(caddrB), .cache_ready_i(ready),
    .cache_rdata_i(crdataB), .cache_rerror_i(crerrB),
    .stall_cnt_o(stallB), .stall_cnt_clr_i(clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index = dut*2 + port.
  logic [AW-1:0] modelQ [4][$];
  logic          pend  [4];
  logic [DW-1:0] pData [4];
  logic          pErr  [4];
  int unsigned   cnt   [4];

  function automatic logic [DW-1:0] cacheData(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic cacheErr(input logic [AW-1:0] a);
    return ^a[7:4];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      modelQ[i].delete();
      pend[i]  = 1'b0;
      pData[i] = '0;
      pErr[i]  = 1'b0;
      cnt[i]   = 0;
    end
  endtask

  // Cache model: answers the address currently presented by each instance.
  task automatic driveCache();
    for (int p = 0; p < NP; p++) begin
      crdataA[p*DW +: DW] = cacheData(caddrA[p*AW +: AW]);
      crerrA[p]           = cacheErr(caddrA[p*AW +: AW]);
      crdataB[p*DW +: DW] = cacheData(caddrB[p*AW +: AW]);
      crerrB[p]           = cacheErr(caddrB[p*AW +: AW]);
    end
  endtask

  task automatic modelCycle(input int d, input int p);
    int            i;
    logic          gO, cvO, rvO, reO, expG, expCv, pop, fire;
    logic [AW-1:0] caO, head;
    logic [DW-1:0] rdO;
    int unsigned   stO, maxCnt;
    string         t;
    i = d*2 + p;
    if (d == 0) begin
      gO = gntA[p]; cvO = cvA[p]; rvO = rvA[p]; reO = rerrA[p];
      caO = caddrA[p*AW +: AW]; rdO = rdataA[p*DW +: DW];
      stO = 32'(stallA[p*16 +: 16]); maxCnt = 65535;
    end else begin
      gO = gntB[p]; cvO = cvB[p]; rvO = rvB[p]; reO = rerrB[p];
      caO = caddrB[p*AW +: AW]; rdO = rdataB[p*DW +: DW];
      stO = 32'(stallB[p*2 +: 2]); maxCnt = 3;
    end
    t     = $sformatf("d%0d.p%0d", d, p);
    expCv = (modelQ[i].size() != 0);
    head  = expCv ? modelQ[i][0] : '0;
    expG  = req[p] && (modelQ[i].size() < 2) && !kill[p];
    pop   = expCv && ready[p];
    fire  = pop && !kill[p];
    checkOutput({t, ".gnt"}, 64'(gO), 64'(expG));
    checkOutput({t, ".cvalid"}, 64'(cvO), 64'(expCv));
    if (expCv) checkOutput({t, ".caddr"}, 64'(caO), 64'(head));
    if (d == 0) begin
      checkOutput({t, ".rvalid"}, 64'(rvO), 64'(pend[i]));
      checkOutput({t, ".rdata"}, 64'(rdO), 64'(pData[i]));
      checkOutput({t, ".rerror"}, 64'(reO), 64'(pErr[i]));
    end else begin
      checkOutput({t, ".rvalid"}, 64'(rvO), 64'(fire));
      if (fire) begin
        checkOutput({t, ".rdata"}, 64'(rdO), 64'(cacheData(head)));
        checkOutput({t, ".rerror"}, 64'(reO), 64'(cacheErr(head)));
      end
    end
    checkOutput({t, ".stall"}, 64'(stO), 64'(cnt[i]));
    if (d == 0) begin
      pend[i] = fire;
      if (fire) begin
        pData[i] = cacheData(head);
        pErr[i]  = cacheErr(head);
      end
    end
    if (pop) void'(modelQ[i].pop_front());
    if (expG) modelQ[i].push_back(addr[p*AW +: AW]);
    if (kill[p]) modelQ[i].delete();
    if (clr) cnt[i] = 0;
    else if (req[p] && !expG && cnt[i] < maxCnt) cnt[i]++;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [1:0] k, input logic [1:0] rd, input logic c);
    @(negedge clk);
    req   = r;
    addr  = {a1, a0};
    kill  = k;
    ready = rd;
    clr   = c;
    driveCache();
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) modelCycle(d, p);
    end
  endtask

  // Asserts reset in the middle of a cycle with the current stimulus still applied.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("rst.A%0d.gnt", p), 64'(gntA[p]), 64'd0);
      checkOutput($sformatf("rst.A%0d.rvalid", p), 64'(rvA[p]), 64'd0);
      checkOutput($sformatf("rst.A%0d.rdata", p), 64'(rdataA[p*DW +: DW]), 64'd0);
      checkOutput($sformatf("rst.A%0d.rerror", p), 64'(rerrA[p]), 64'd0);
      checkOutput($sformatf("rst.A%0d.cvalid", p), 64'(cvA[p]), 64'd0);
      checkOutput($sformatf("rst.A%0d.caddr", p), 64'(caddrA[p*AW +: AW]), 64'd0);
      checkOutput($sformatf("rst.A%0d.stall", p), 64'(stallA[p*16 +: 16]), 64'd0);
      checkOutput($sformatf("rst.B%0d.gnt", p), 64'(gntB[p]), 64'd0);
      checkOutput($sformatf("rst.B%0d.rvalid", p), 64'(rvB[p]), 64'd0);
      checkOutput($sformatf("rst.B%0d.rdata", p), 64'(rdataB[p*DW +: DW]), 64'd0);
      checkOutput($sformatf("rst.B%0d.rerror", p), 64'(rerrB[p]), 64'd0);
      checkOutput($sformatf("rst.B%0d.cvalid", p), 64'(cvB[p]), 64'd0);
      checkOutput($sformatf("rst.B%0d.stall", p), 64'(stallB[p*2 +: 2]), 64'd0);
    end
    resetModel();
    req   = '0;
    kill  = '0;
    ready = '0;
    clr   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed scenarios first, then a long randomized run.
  initial begin
    logic [1:0] r, k, rd;
    logic       c;
    rst     = 1'b0;
    req     = '0;
    kill    = '0;
    ready   = 2'b11;
    clr     = 1'b0;
    addr    = '1;
    crdataA = '1;
    crdataB = '1;
    crerrA  = '1;
    crerrB  = '1;
    resetModel();
    #1;
    rst = 1'b1;
    ready = '0;
    doReset();

    $display("[TB] back-to-back fetches");
    for (int n = 0; n < 3; n++) applyStimulus(2'b01, 32'hA0 + 32'(4*n), 32'h0, 2'b00, 2'b11, 1'b0);
    for (int n = 0; n < 3; n++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0);

    $display("[TB] full queue");
    applyStimulus(2'b01, 32'h10, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h14, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h18, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h18, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h18, 32'h0, 2'b00, 2'b01, 1'b0);
    applyStimulus(2'b01, 32'h18, 32'h0, 2'b00, 2'b01, 1'b0);
    for (int n = 0; n < 4; n++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0);

    $display("[TB] kill");
    applyStimulus(2'b01, 32'h200, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b01, 32'h204, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b01, 2'b01, 1'b0);
    applyStimulus(2'b01, 32'h100, 32'h0, 2'b00, 2'b01, 1'b0);
    for (int n = 0; n < 3; n++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0);

    $display("[TB] single fetch, ready one cycle later");
    applyStimulus(2'b01, 32'h40, 32'h0, 2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b01, 1'b0);
    for (int n = 0; n < 2; n++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0);

    $display("[TB] stall counter saturation and clear");
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b1);
    for (int n = 0; n < 5; n++) applyStimulus(2'b01, 32'h300, 32'h0, 2'b01, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("sat.B0", 64'(stallB[1:0]), 64'd3);
    checkOutput("cnt.A0", 64'(stallA[15:0]), 64'd5);
    applyStimulus(2'b01, 32'h300, 32'h0, 2'b01, 2'b11, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("clr.B0", 64'(stallB[1:0]), 64'd0);
    checkOutput("clr.A0", 64'(stallA[15:0]), 64'd0);

    $display("[TB] port0 stalled, port1 streaming, then reset");
    for (int n = 0; n < 6; n++)
      applyStimulus(2'b11, 32'h400 + 32'(4*n), 32'h800 + 32'(4*n), 2'b00, 2'b10, 1'b0);
    doReset();
    for (int n = 0; n < 4; n++) applyStimulus(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      r  = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      k  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      rd = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      c  = ($urandom_range(0, 63) == 0);
      applyStimulus(r, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, k, rd, c);
      if (n % 1000 == 999) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
